fft_frame_sched: RTL and testbench
==================================

// Module: fft_frame_sched
// PURPOSE
//  Frame scheduler sharing one fft_64 engine between two sample requesters.
//  - Arbitrates whole 64-sample frames round-robin.
//  - Drives the engine's start/load sequence and collects its output stream.
//  - Returns each result sample tagged with channel and bin index.
//  - Sits between the capture front-ends and fft_64; instantiated once per engine.
// PARAMETERS
//  N           64     samples per frame (power of two; engine size)
//  DW          16     sample width, signed Q8.8 real and imag
//  TIMEOUT_CYC 1024   max cycles waiting for fft_valid after the last load
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  req           in   2      per-channel frame request; held high until gnt
//  gnt           out  2      one-hot grant, high for exactly the N LOAD cycles
//  ch_valid      in   2      per-channel sample valid
//  ch0_real/imag in   DW     channel 0 sample
//  ch1_real/imag in   DW     channel 1 sample
//  fft_ready     in   1      engine idle and able to accept start
//  fft_start     out  1      one-cycle start pulse to engine
//  fft_in_real/imag out DW   sample to engine during LOAD
//  fft_valid     in   1      engine output valid; N consecutive cycles
//  fft_out_real/imag in DW   engine output sample
//  res_valid     out  1      result sample valid
//  res_ch        out  1      channel owning the result
//  res_idx       out  log2N  bin index of the result
//  res_real/imag out  DW     result sample
//  res_last      out  1      high with final bin of a frame
//  underrun      out  1      one-cycle pulse: granted channel dropped ch_valid during LOAD
//  timeout       out  1      one-cycle pulse: WAIT exceeded TIMEOUT_CYC
//  busy          out  1      high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; RR pointer favours ch0; counters 0.
//  - rst mid-frame aborts immediately. No partial result is emitted afterwards.
//  - FSM: IDLE -> START -> LOAD -> WAIT -> DRAIN -> IDLE.
//  - IDLE: if fft_ready & |req, pick a channel and go to START next cycle.
//    - One req: that channel. Both: channel != last granted.
//    - RR pointer updates on the pick.
//  - START: fft_start=1 for exactly this cycle; gnt not yet asserted.
//  - LOAD: N cycles, cnt 0..N-1. gnt[sel]=1.
//    - fft_in = selected channel sample (combinational mux).
//    - If ch_valid[sel]=0 in any LOAD cycle: fft_in=0 for that cycle, underrun pulses, LOAD still lasts N cycles.
//    - Unselected channel's req/data ignored.
//    - Outside LOAD: fft_in=0, gnt=0.
//  - WAIT: count cycles.
//    - fft_valid=1 -> DRAIN, capturing that sample as bin 0.
//    - Count reaches TIMEOUT_CYC -> timeout pulse, go to IDLE, no results.
//  - DRAIN: one registered result per fft_valid cycle (latency 1 from fft_valid to res_valid).
//    - res_ch=sel; res_idx = output count; res_last at count N-1, then IDLE.
//    - If fft_valid drops early, res_valid=0 that cycle and the count holds.
//  - req arriving during a frame waits; next frame may start the cycle after DRAIN ends, if fft_ready.
//  - Data passes unmodified; no scaling or saturation in this block.
// CONFIGURATION
//  FFT_SCHED_BITREV_EN
//    - Defined: res_idx = bit-reverse(output count), for engines emitting bit-reversed order.
//    - Undefined: res_idx = output count (natural order).
// TESTING
//  1. ch0 impulse: req=01, ch0_real=0x0100 at load cnt 0, else 0 -> fft_start one pulse,
//     gnt=01 for 64 cycles, 64 res_valid with res_ch=0, all res_real=0x0100, res_imag=0, res_last on idx 63.
//  2. req=11 held across two frames -> grants ch0 then ch1. The second START follows the first res_last
//     by 1 cycle (fft_ready=1); ch1 DC 0x0010 gives bin0 real=0x0400, other bins 0.
//  3. ch0 drops ch_valid at load cnt 10 for 1 cycle -> underrun one pulse, fft_in_real=0 that cycle, LOAD still 64 cycles.
//  4. Model engine never asserts fft_valid -> timeout pulses after 1024 WAIT cycles, busy=0 next cycle, no res_valid.
//  5. Assert rst at load cnt 30 -> all outputs 0 asynchronously.
//     After release with req=01, a fresh frame loads 64 samples from cnt 0.
//  6. Build with FFT_SCHED_BITREV_EN: 4th result (count 3) reports res_idx=48 (6'b110000); without it, res_idx=3.

Source files
------------

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: round-robin frame scheduler sharing one fft_64 engine between two sample requesters
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   i_req       / o_gnt         per-channel frame request / one-hot grant, high for the N LOAD cycles
//   i_ch_valid                  per-channel sample valid
//   i_ch0_real/imag, i_ch1_*    per-channel sample data
//   i_fft_ready                 engine idle and able to accept a start
//   o_fft_start                 one-cycle engine start pulse
//   o_fft_in_real/imag          sample presented to the engine during LOAD, 0 otherwise
//   i_fft_valid, i_fft_out_*    engine output stream, N consecutive valid cycles nominally
//   o_res_valid/ch/idx/real/imag/last  registered result sample tagged with channel and bin
//   o_underrun                  one-cycle pulse: granted channel had no valid sample in a LOAD cycle
//   o_timeout                   one-cycle pulse: engine gave no output within TIMEOUT_CYC WAIT cycles
//   o_busy                      high in every state except IDLE
// Build option: FFT_SCHED_BITREV_EN reports o_res_idx as the bit-reversed output count.
module fft_frame_sched #(
    parameter int N           = 64,
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           i_req,
    output logic [1:0]           o_gnt,
    input  logic [1:0]           i_ch_valid,
    input  logic [DW-1:0]        i_ch0_real,
    input  logic [DW-1:0]        i_ch0_imag,
    input  logic [DW-1:0]        i_ch1_real,
    input  logic [DW-1:0]        i_ch1_imag,
    input  logic                 i_fft_ready,
    output logic                 o_fft_start,
    output logic [DW-1:0]        o_fft_in_real,
    output logic [DW-1:0]        o_fft_in_imag,
    input  logic                 i_fft_valid,
    input  logic [DW-1:0]        i_fft_out_real,
    input  logic [DW-1:0]        i_fft_out_imag,
    output logic                 o_res_valid,
    output logic                 o_res_ch,
    output logic [$clog2(N)-1:0] o_res_idx,
    output logic [DW-1:0]        o_res_real,
    output logic [DW-1:0]        o_res_imag,
    output logic                 o_res_last,
    output logic                 o_underrun,
    output logic                 o_timeout,
    output logic                 o_busy
);
    localparam int LW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, START, LOAD, WAIT, DRAIN} state_t;

    state_t        r_state, w_next;
    logic          r_sel;
    logic [LW-1:0] r_cnt;
    logic [TW-1:0] r_wcnt;
    logic          r_res_valid, r_res_ch, r_res_last;
    logic [LW-1:0] r_res_idx, w_idx;
    logic [DW-1:0] r_res_real, r_res_imag;
    logic          w_pick, w_out, w_sv;

    // r_sel is both the channel being served and the last-granted channel the round robin steers away from
    assign w_pick = (i_req[0] && i_req[1]) ? ~r_sel : i_req[1];
    assign w_out  = i_fft_valid && (r_state == WAIT || r_state == DRAIN);
    assign w_sv   = i_ch_valid[r_sel];

`ifdef FFT_SCHED_BITREV_EN
    for (genvar g = 0; g < LW; g++) begin : g_rev
        assign w_idx[g] = r_cnt[LW-1-g];
    end
`else
    assign w_idx = r_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        o_gnt         = '0;
        o_fft_start   = 1'b0;
        o_fft_in_real = '0;
        o_fft_in_imag = '0;
        o_underrun    = 1'b0;
        o_timeout     = 1'b0;
        case (r_state)
            IDLE:  if (i_fft_ready && |i_req) w_next = START;
            START: begin
                o_fft_start = 1'b1;
                w_next      = LOAD;
            end
            LOAD: begin
                o_gnt[r_sel]  = 1'b1;
                o_underrun    = ~w_sv;
                o_fft_in_real = !w_sv ? '0 : r_sel ? i_ch1_real : i_ch0_real;
                o_fft_in_imag = !w_sv ? '0 : r_sel ? i_ch1_imag : i_ch0_imag;
                if (r_cnt == LW'(N - 1)) w_next = WAIT;
            end
            WAIT: begin
                if (i_fft_valid) w_next = DRAIN;
                else if (r_wcnt == TW'(TIMEOUT_CYC - 1)) begin
                    o_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            DRAIN:   if (i_fft_valid && r_cnt == LW'(N - 1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign o_busy = r_state != IDLE;

    // r_cnt serves LOAD and then the output count; it wraps to 0 at the end of each phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel       <= 1'b1;
            r_cnt       <= '0;
            r_wcnt      <= '0;
            r_res_valid <= 1'b0;
            r_res_ch    <= 1'b0;
            r_res_idx   <= '0;
            r_res_real  <= '0;
            r_res_imag  <= '0;
            r_res_last  <= 1'b0;
        end else begin
            if (r_state == IDLE && w_next == START) r_sel <= w_pick;
            if (r_state == LOAD || w_out) r_cnt <= r_cnt + 1'b1;
            r_wcnt      <= (r_state == WAIT) ? r_wcnt + 1'b1 : '0;
            r_res_valid <= w_out;
            r_res_last  <= w_out && r_cnt == LW'(N - 1);
            if (w_out) begin
                r_res_ch   <= r_sel;
                r_res_idx  <= w_idx;
                r_res_real <= i_fft_out_real;
                r_res_imag <= i_fft_out_imag;
            end
        end
    end

    assign o_res_valid = r_res_valid;
    assign o_res_ch    = r_res_ch;
    assign o_res_idx   = r_res_idx;
    assign o_res_real  = r_res_real;
    assign o_res_imag  = r_res_imag;
    assign o_res_last  = r_res_last;
endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: randomized bench with a behavioural DFT engine, requester model and arbitration model
module tb_fft_frame_sched;
    typedef struct packed {
        logic        ch;
        logic [5:0]  idx;
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } res_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  req = '0, ch_valid = '0, gnt;
    logic [15:0] ch0_real = '0, ch0_imag = '0, ch1_real = '0, ch1_imag = '0;
    logic        fft_ready = 1'b1, fft_start, fft_valid = 1'b0;
    logic [15:0] fft_in_real, fft_in_imag, fft_out_real = '0, fft_out_imag = '0;
    logic        res_valid, res_ch, res_last, underrun, timeout, busy;
    logic [5:0]  res_idx;
    logic [15:0] res_real, res_imag;

    fft_frame_sched dut (
        .clk(clk), .rst(rst), .i_req(req), .o_gnt(gnt), .i_ch_valid(ch_valid),
        .i_ch0_real(ch0_real), .i_ch0_imag(ch0_imag), .i_ch1_real(ch1_real), .i_ch1_imag(ch1_imag),
        .i_fft_ready(fft_ready), .o_fft_start(fft_start), .o_fft_in_real(fft_in_real), .o_fft_in_imag(fft_in_imag),
        .i_fft_valid(fft_valid), .i_fft_out_real(fft_out_real), .i_fft_out_imag(fft_out_imag),
        .o_res_valid(res_valid), .o_res_ch(res_ch), .o_res_idx(res_idx), .o_res_real(res_real),
        .o_res_imag(res_imag), .o_res_last(res_last), .o_underrun(underrun), .o_timeout(timeout), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0;
    logic [15:0] s_re[2][64], s_im[2][64];
    bit          vpat[2][64];
    int          ptr[2], pend[2];
    logic [15:0] ld_re[64], ld_im[64], out_re[64], out_im[64], obs_in_re[64], obs_in_im[64];
    int          ld_n, lat_cnt, em_k, cyc;
    bit          em_on, armed, no_resp, gaps, m_last, cur_ch, busy_after_to, prev_to;
    res_t        exp_q[$], obs_q[$];
    int          start_cyc[$], res_last_cyc[$], gnt_ch_q[$], exp_pick_q[$], under_idx[$];
    int          n_start, n_gnt, n_under, n_to, to_cyc, last_gnt_cyc, bad_gnt;

    function automatic logic [5:0] ref_idx(input int k);
        logic [5:0] v;
        v = 6'(k);
`ifdef FFT_SCHED_BITREV_EN
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] rnd16();
        return 16'(int'($urandom_range(2048)) - 1024);
    endfunction

    // Reference engine: plain DFT of the 64 loaded samples
    task automatic dft();
        real sr, si, a, xr, xi;
        for (int k = 0; k < 64; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < 64; n++) begin
                a  = 2.0 * 3.14159265358979 * n * k / 64.0;
                xr = $itor($signed(ld_re[n]));
                xi = $itor($signed(ld_im[n]));
                sr = sr + xr * $cos(a) + xi * $sin(a);
                si = si + xi * $cos(a) - xr * $sin(a);
            end
            out_re[k] = 16'($rtoi(sr + (sr < 0.0 ? -0.5 : 0.5)));
            out_im[k] = 16'($rtoi(si + (si < 0.0 ? -0.5 : 0.5)));
        end
    endtask

    task automatic clr();
        obs_q.delete(); exp_q.delete(); start_cyc.delete(); res_last_cyc.delete();
        gnt_ch_q.delete(); exp_pick_q.delete(); under_idx.delete();
        n_start = 0; n_gnt = 0; n_under = 0; n_to = 0; bad_gnt = 0; ld_n = 0;
        em_on = 0; armed = 0; gaps = 0; no_resp = 0; busy_after_to = 1; prev_to = 0;
        for (int c = 0; c < 2; c++) begin
            ptr[c] = 0;
            pend[c] = 0;
            for (int k = 0; k < 64; k++) begin
                vpat[c][k] = 1;
                s_re[c][k] = '0;
                s_im[c][k] = '0;
            end
        end
    endtask

    task automatic fill(input int c);
        for (int k = 0; k < 64; k++) begin
            s_re[c][k] = rnd16();
            s_im[c][k] = rnd16();
        end
    endtask

    // One clock: drive requesters and engine after the edge, observe the DUT at the falling edge
    task automatic tick();
        int   c;
        bit   p;
        res_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            req[i]      = pend[i] > 0;
            ch_valid[i] = vpat[i][ptr[i] % 64];
        end
        ch0_real = s_re[0][ptr[0] % 64];
        ch0_imag = s_im[0][ptr[0] % 64];
        ch1_real = s_re[1][ptr[1] % 64];
        ch1_imag = s_im[1][ptr[1] % 64];
        fft_valid = 0;
        fft_out_real = '0;
        fft_out_imag = '0;
        if (armed) begin
            if (lat_cnt == 0) begin
                armed = 0;
                em_on = !no_resp;
                em_k  = 0;
            end else lat_cnt--;
        end
        if (em_on && !(gaps && em_k > 0 && $urandom_range(3) == 0)) begin
            fft_valid    = 1;
            fft_out_real = out_re[em_k];
            fft_out_imag = out_im[em_k];
            e = '{cur_ch, ref_idx(em_k), out_re[em_k], out_im[em_k], em_k == 63};
            exp_q.push_back(e);
            em_k++;
            if (em_k == 64) em_on = 0;
        end
        @(negedge clk);
        cyc++;
        if (prev_to) busy_after_to = busy;
        prev_to = timeout;
        if (gnt == 2'b11) bad_gnt++;
        if (fft_start) begin
            n_start++;
            start_cyc.push_back(cyc);
            p = (req[0] && req[1]) ? !m_last : req[1];
            m_last = p;
            cur_ch = p;
            exp_pick_q.push_back(int'(p));
            ld_n = 0;
        end
        if (gnt != 2'b00) begin
            c = int'(gnt[1]);
            if (ld_n == 0) begin
                gnt_ch_q.push_back(c);
                pend[c]--;
            end
            if (ld_n < 64) begin
                ld_re[ld_n] = fft_in_real;
                ld_im[ld_n] = fft_in_imag;
                obs_in_re[ld_n] = fft_in_real;
                obs_in_im[ld_n] = fft_in_imag;
            end
            if (underrun) under_idx.push_back(ld_n);
            ld_n++;
            n_gnt++;
            ptr[c]++;
            last_gnt_cyc = cyc;
            if (ld_n == 64) begin
                dft();
                armed   = 1;
                lat_cnt = $urandom_range(6);
            end
        end
        if (underrun) n_under++;
        if (timeout) begin
            n_to++;
            to_cyc = cyc;
        end
        if (res_valid) begin
            e = '{res_ch, res_idx, res_real, res_imag, res_last};
            obs_q.push_back(e);
            if (res_last) res_last_cyc.push_back(cyc);
        end
    endtask

    task automatic run(input int budget, output bit ok);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((busy || pend[0] > 0 || pend[1] > 0 || em_on || armed) && n < budget);
        ok = n < budget;
    endtask

    task automatic test_reset();
        clr();
        rst = 1;
        repeat (3) tick();
        n_chk++; if (gnt !== 2'b00) $display("FAIL rst_gnt got=%b exp=00", gnt); else n_pass++;
        n_chk++; if (fft_start !== 1'b0) $display("FAIL rst_start got=%b exp=0", fft_start); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got=%b exp=0", res_valid); else n_pass++;
        n_chk++; if ({underrun, timeout} !== 2'b00) $display("FAIL rst_pulses got=%b exp=00", {underrun, timeout}); else n_pass++;
        n_chk++; if ({fft_in_real, fft_in_imag} !== 32'h0) $display("FAIL rst_fft_in got=%h exp=0", {fft_in_real, fft_in_imag}); else n_pass++;
        n_chk++; if ({res_ch, res_idx, res_real, res_imag, res_last} !== 40'h0)
            $display("FAIL rst_res got=%h exp=0", {res_ch, res_idx, res_real, res_imag, res_last}); else n_pass++;
        rst = 0;
        m_last = 1;
    endtask

    task automatic test_two_frames();
        bit ok;
        logic [15:0] e_re;
        clr();
        fill(0);
        for (int k = 0; k < 64; k++) s_re[1][k] = 16'h0010;
        gaps = 1;
        pend[0] = 1;
        pend[1] = 1;
        run(2000, ok);
        n_chk++; if (!ok) $display("FAIL two_budget got=expired exp=done"); else n_pass++;
        n_chk++; if (n_start !== 2) $display("FAIL two_starts got=%0d exp=2", n_start); else n_pass++;
        n_chk++; if (gnt_ch_q.size() != 2 || gnt_ch_q[0] !== 0 || gnt_ch_q[1] !== 1)
            $display("FAIL two_order got=%p exp=0,1", gnt_ch_q); else n_pass++;
        n_chk++; if (start_cyc.size() < 2 || res_last_cyc.size() < 1 || start_cyc[1] !== res_last_cyc[0] + 1)
            $display("FAIL two_restart got=%p exp=res_last %p +1", start_cyc, res_last_cyc); else n_pass++;
        n_chk++; if (obs_q.size() != 128 || exp_q.size() != 128)
            $display("FAIL two_count got=%0d exp=128 (model %0d)", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL two_res[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        for (int i = 64; i < obs_q.size(); i++) begin
            e_re = (i == 64) ? 16'h0400 : 16'h0000;
            n_chk++; if ({obs_q[i].ch, obs_q[i].re, obs_q[i].im} !== {1'b1, e_re, 16'h0000})
                $display("FAIL two_dc[%0d] got=%h exp=%h", i - 64, {obs_q[i].ch, obs_q[i].re, obs_q[i].im}, {1'b1, e_re, 16'h0000});
            else n_pass++;
        end
    endtask

    task automatic test_impulse();
        bit ok;
        res_t e;
        logic [5:0] i3;
        clr();
        s_re[0][0] = 16'h0100;
        pend[0] = 1;
        run(2000, ok);
        n_chk++; if (!ok) $display("FAIL imp_budget got=expired exp=done"); else n_pass++;
        n_chk++; if (n_start !== 1) $display("FAIL imp_starts got=%0d exp=1", n_start); else n_pass++;
        n_chk++; if (n_gnt !== 64) $display("FAIL imp_gnt_len got=%0d exp=64", n_gnt); else n_pass++;
        n_chk++; if (gnt_ch_q.size() != 1 || gnt_ch_q[0] !== 0) $display("FAIL imp_gnt_ch got=%p exp=0", gnt_ch_q); else n_pass++;
        n_chk++; if (bad_gnt !== 0) $display("FAIL imp_onehot got=%0d exp=0", bad_gnt); else n_pass++;
        n_chk++; if (obs_q.size() != 64) $display("FAIL imp_count got=%0d exp=64", obs_q.size()); else n_pass++;
        for (int i = 0; i < obs_q.size(); i++) begin
            e = '{1'b0, ref_idx(i), 16'h0100, 16'h0000, i == 63};
            n_chk++; if (obs_q[i] !== e) $display("FAIL imp_res[%0d] got=%h exp=%h", i, obs_q[i], e); else n_pass++;
        end
`ifdef FFT_SCHED_BITREV_EN
        i3 = 6'd48;
`else
        i3 = 6'd3;
`endif
        n_chk++; if (obs_q.size() < 4 || obs_q[3].idx !== i3) $display("FAIL imp_idx3 got=%0d exp=%0d", obs_q[3].idx, i3); else n_pass++;
    endtask

    task automatic test_underrun();
        bit ok;
        int errs;
        logic [31:0] e;
        clr();
        fill(0);
        fill(1);
        for (int k = 0; k < 64; k++) vpat[1][k] = $urandom_range(1) == 1;
        vpat[0][10] = 0;
        pend[0] = 1;
        run(2000, ok);
        n_chk++; if (!ok) $display("FAIL und_budget got=expired exp=done"); else n_pass++;
        n_chk++; if (n_under !== 1) $display("FAIL und_pulses got=%0d exp=1", n_under); else n_pass++;
        n_chk++; if (under_idx.size() != 1 || under_idx[0] !== 10) $display("FAIL und_at got=%p exp=10", under_idx); else n_pass++;
        n_chk++; if (n_gnt !== 64) $display("FAIL und_gnt_len got=%0d exp=64", n_gnt); else n_pass++;
        errs = 0;
        for (int k = 0; k < 64; k++) begin
            e = (k == 10) ? 32'h0 : {s_re[0][k], s_im[0][k]};
            if ({obs_in_re[k], obs_in_im[k]} !== e) errs++;
        end
        n_chk++; if (errs !== 0) $display("FAIL und_fft_in got=%0d bad exp=0 (cnt10 %h)", errs, obs_in_re[10]); else n_pass++;
        n_chk++; if (obs_q.size() != 64 || obs_q != exp_q) $display("FAIL und_res got=%0d results exp=64 matching", obs_q.size()); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        clr();
        fill(1);
        no_resp = 1;
        pend[1] = 1;
        run(3000, ok);
        n_chk++; if (!ok) $display("FAIL to_budget got=expired exp=done"); else n_pass++;
        n_chk++; if (n_to !== 1) $display("FAIL to_pulses got=%0d exp=1", n_to); else n_pass++;
        n_chk++; if (to_cyc - last_gnt_cyc !== 1024) $display("FAIL to_wait got=%0d exp=1024", to_cyc - last_gnt_cyc); else n_pass++;
        n_chk++; if (busy_after_to !== 1'b0) $display("FAIL to_busy got=%b exp=0", busy_after_to); else n_pass++;
        n_chk++; if (obs_q.size() != 0) $display("FAIL to_results got=%0d exp=0", obs_q.size()); else n_pass++;
        n_chk++; if (n_gnt !== 64) $display("FAIL to_gnt_len got=%0d exp=64", n_gnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int f;
        clr();
        fill(0);
        fill(1);
        gaps = 1;
        pend[0] = $urandom_range(1, 3);
        pend[1] = $urandom_range(1, 3);
        f = pend[0] + pend[1];
        run(20000, ok);
        n_chk++; if (!ok) $display("FAIL b2b_budget got=expired exp=done"); else n_pass++;
        n_chk++; if (n_start !== f) $display("FAIL b2b_starts got=%0d exp=%0d", n_start, f); else n_pass++;
        n_chk++; if (gnt_ch_q != exp_pick_q) $display("FAIL b2b_order got=%p exp=%p", gnt_ch_q, exp_pick_q); else n_pass++;
        n_chk++; if (obs_q.size() != 64 * f) $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), 64 * f); else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_res[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        for (int i = 1; i < start_cyc.size() && i <= res_last_cyc.size(); i++) begin
            n_chk++; if (start_cyc[i] !== res_last_cyc[i-1] + 1)
                $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", i, start_cyc[i], res_last_cyc[i-1] + 1); else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        int n, errs;
        clr();
        fill(0);
        pend[0] = 1;
        n = 0;
        while (ld_n < 30 && n < 300) begin
            tick();
            n++;
        end
        n_chk++; if (ld_n !== 30) $display("FAIL rm_reach got=%0d exp=30", ld_n); else n_pass++;
        @(posedge clk);
        #1;
        n_chk++; if (gnt !== 2'b01) $display("FAIL rm_loading got=%b exp=01", gnt); else n_pass++;
        #1 rst = 1;
        #1;
        n_chk++; if ({gnt, fft_start, fft_in_real, fft_in_imag, underrun, timeout, busy} !== 38'h0)
            $display("FAIL rm_async_ctl got=%h exp=0", {gnt, fft_start, fft_in_real, fft_in_imag, underrun, timeout, busy}); else n_pass++;
        n_chk++; if ({res_valid, res_ch, res_idx, res_real, res_imag, res_last} !== 41'h0)
            $display("FAIL rm_async_res got=%h exp=0", {res_valid, res_ch, res_idx, res_real, res_imag, res_last}); else n_pass++;
        repeat (2) tick();
        rst = 0;
        m_last = 1;
        clr();
        fill(0);
        pend[0] = 1;
        run(2000, ok);
        n_chk++; if (!ok) $display("FAIL rm_budget got=expired exp=done"); else n_pass++;
        n_chk++; if (n_gnt !== 64 || n_start !== 1) $display("FAIL rm_frame got=%0d gnt %0d start exp=64 1", n_gnt, n_start); else n_pass++;
        errs = 0;
        for (int k = 0; k < 64; k++) if ({obs_in_re[k], obs_in_im[k]} !== {s_re[0][k], s_im[0][k]}) errs++;
        n_chk++; if (errs !== 0) $display("FAIL rm_fft_in got=%0d bad exp=0", errs); else n_pass++;
        n_chk++; if (obs_q.size() != 64 || obs_q != exp_q) $display("FAIL rm_res got=%0d results exp=64 matching", obs_q.size()); else n_pass++;
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_two_frames();
        test_impulse();
        test_underrun();
        test_timeout();
        test_back_to_back();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
